// File: rtl/xsim_pkg.sv
// Shared types and helpers for the simulator message-source serializer.
// Holds the header field widths, the header packing function and the FSM state type.
package xsim_pkg;

    localparam int METHOD_W    = 16;
    localparam int LEN_FIELD_W = 16;

    typedef enum logic {
        IDLE,
        PAYLOAD
    } ser_state_t;

    // The low header field carries the total beat count, header included.
    function automatic logic [31:0] make_header(input logic [METHOD_W-1:0]    method,
                                                input logic [LEN_FIELD_W-1:0] len);
        return {method, len + LEN_FIELD_W'(1)};
    endfunction

endpackage

// File: rtl/xsim_msg_fifo.sv
// Small message FIFO holding packed {method, len, data} entries.
// Pointers carry one extra bit so full and empty can be told apart.
module xsim_msg_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/xsim_msg_serializer.sv
// Buffers whole portal messages and streams each as a header beat followed by
// its payload words, gaplessly, into a sink that has no backpressure.
module xsim_msg_serializer
    import xsim_pkg::*;
#(
    parameter  int MAX_WORDS = 16,
    parameter  int DEPTH     = 2,
    parameter  int PORTAL_ID = 0,
    localparam int LENW      = $clog2(MAX_WORDS + 1)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      msg_valid,
    output logic                      msg_ready,
    input  logic [METHOD_W-1:0]       msg_method,
    input  logic [LENW-1:0]           msg_len,
    input  logic [MAX_WORDS*32-1:0]   msg_data,
    output logic [31:0]               portal,
    output logic                      en_beat,
    output logic [31:0]               beat,
    output logic                      busy,
    output logic                      len_err,
    output logic [31:0]               beat_count
);

    localparam int DATA_W  = MAX_WORDS * 32;
    localparam int ENTRY_W = METHOD_W + LENW + DATA_W;

    ser_state_t            state;
    ser_state_t            next_state;
    logic [DATA_W-1:0]     shift_reg;
    logic [LENW-1:0]       remaining;

    logic                  accept;
    logic                  len_bad;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_din;
    logic [ENTRY_W-1:0]    fifo_dout;

    logic [METHOD_W-1:0]   head_method;
    logic [LENW-1:0]       head_len;
    logic [DATA_W-1:0]     head_data;

    logic                  load;
    logic                  shift;
    logic                  next_en;
    logic [31:0]           next_beat;

    assign portal    = 32'(PORTAL_ID);
    assign msg_ready = !fifo_full;
    assign accept    = msg_valid && msg_ready;
    assign len_bad   = (msg_len > LENW'(MAX_WORDS));
    assign fifo_push = accept && !len_bad;
    assign fifo_din  = {msg_method, msg_len, msg_data};

    assign head_method = fifo_dout[ENTRY_W-1 -: METHOD_W];
    assign head_len    = fifo_dout[DATA_W +: LENW];
    assign head_data   = fifo_dout[DATA_W-1:0];

    assign busy = (state != IDLE) || !fifo_empty;

    xsim_msg_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // After the last payload word the FSM returns to IDLE, where a waiting entry
    // is popped and its header registered on the very next edge: no bubble.
    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        next_en    = 1'b0;
        next_beat  = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    load      = 1'b1;
                    next_en   = 1'b1;
                    next_beat = make_header(head_method, LEN_FIELD_W'(head_len));
                    if (head_len != '0) next_state = PAYLOAD;
                end
            end
            PAYLOAD: begin
                shift     = 1'b1;
                next_en   = 1'b1;
                next_beat = shift_reg[31:0];
                if (remaining == LENW'(1)) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            shift_reg  <= '0;
            remaining  <= '0;
            en_beat    <= 1'b0;
            beat       <= '0;
            beat_count <= '0;
            len_err    <= 1'b0;
        end else begin
            state   <= next_state;
            en_beat <= next_en;
            beat    <= next_beat;
            if (next_en) beat_count <= beat_count + 32'd1;
            if (accept && len_bad) len_err <= 1'b1;
            if (load) begin
                shift_reg <= head_data;
                remaining <= head_len;
            end else if (shift) begin
                shift_reg <= shift_reg >> 32;
                remaining <= remaining - LENW'(1);
            end
        end
    end

endmodule

// File: tb/tb_xsim_msg_serializer.sv
// Directed self-checking bench for xsim_msg_serializer (MAX_WORDS=16, DEPTH=2).
// A negedge monitor records every beat with the index of the edge that registered it.
module tb_xsim_msg_serializer;

    localparam int MAXW = 16;
    localparam int LENW = $clog2(MAXW + 1);
    localparam int DW   = MAXW * 32;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            msg_valid = 1'b0;
    logic            msg_ready;
    logic [15:0]     msg_method = '0;
    logic [LENW-1:0] msg_len = '0;
    logic [DW-1:0]   msg_data = '0;
    logic [31:0]     portal;
    logic            en_beat;
    logic [31:0]     beat;
    logic            busy;
    logic            len_err;
    logic [31:0]     beat_count;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int nrdy   = 0;
    logic [31:0] bq[$];
    int          cq[$];

    xsim_msg_serializer #(
        .MAX_WORDS (MAXW),
        .DEPTH     (2),
        .PORTAL_ID (0)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_method (msg_method),
        .msg_len    (msg_len),
        .msg_data   (msg_data),
        .portal     (portal),
        .en_beat    (en_beat),
        .beat       (beat),
        .busy       (busy),
        .len_err    (len_err),
        .beat_count (beat_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST && !msg_ready) nrdy++;
        if (en_beat) begin
            bq.push_back(beat);
            cq.push_back(cyc);
        end
    end

    task automatic clear_log();
        bq.delete();
        cq.delete();
        nrdy = 0;
    endtask

    task automatic send_msg(input logic [15:0] m, input logic [LENW-1:0] l,
                            input logic [DW-1:0] d, output int acc_cyc);
        int waited = 0;
        msg_method = m;
        msg_len    = l;
        msg_data   = d;
        msg_valid  = 1'b1;
        while (!msg_ready && waited < 50) begin
            @(posedge CLK); #1;
            waited++;
        end
        if (!msg_ready) begin
            checks++; fails++;
            $display("[TB] FAIL send_timeout method=%h ready stuck at 0", m);
            acc_cyc = -1;
        end else begin
            @(posedge CLK); #1;
            acc_cyc = cyc;
        end
        msg_valid = 1'b0;
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        logic [31:0]   exp[4];
        logic [31:0]   got;
        int e0;
        clear_log();
        checks++;
        if (portal !== 32'd0) begin fails++; $display("[TB] FAIL portal got=%h want=0", portal); end
        d = '0;
        d[31:0] = 32'h11; d[63:32] = 32'h22; d[95:64] = 32'h33;
        exp[0] = 32'h0005_0004; exp[1] = 32'h11; exp[2] = 32'h22; exp[3] = 32'h33;
        send_msg(16'd5, LENW'(3), d, e0);
        repeat (8) @(posedge CLK);
        #1;
        checks++;
        if (bq.size() !== 4) begin fails++; $display("[TB] FAIL single_nbeats got=%0d want=4", bq.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < bq.size()) ? bq[i] : 32'hxxxxxxxx;
            checks++;
            if (got !== exp[i]) begin fails++; $display("[TB] FAIL single_beat%0d got=%h want=%h", i, got, exp[i]); end
            checks++;
            if (i < cq.size() && cq[i] !== e0 + 1 + i) begin
                fails++; $display("[TB] FAIL single_edge%0d got=%0d want=%0d", i, cq[i], e0 + 1 + i);
            end
        end
        checks++;
        if (en_beat !== 1'b0) begin fails++; $display("[TB] FAIL single_en_after got=%b want=0", en_beat); end
        checks++;
        if (beat_count !== 32'd4) begin fails++; $display("[TB] FAIL single_count got=%0d want=4", beat_count); end
    endtask

    task automatic test_zero_len();
        int e0;
        clear_log();
        send_msg(16'd7, LENW'(0), '0, e0);
        repeat (5) @(posedge CLK);
        #1;
        checks++;
        if (bq.size() !== 1) begin fails++; $display("[TB] FAIL zero_nbeats got=%0d want=1", bq.size()); end
        checks++;
        if (bq.size() > 0 && bq[0] !== 32'h0007_0001) begin fails++; $display("[TB] FAIL zero_hdr got=%h want=00070001", bq[0]); end
        checks++;
        if (busy !== 1'b0) begin fails++; $display("[TB] FAIL zero_busy got=%b want=0", busy); end
        checks++;
        if (beat_count !== 32'd5) begin fails++; $display("[TB] FAIL zero_count got=%0d want=5", beat_count); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic [31:0]   exp[9];
        logic [31:0]   got;
        logic [31:0]   base;
        int e0;
        clear_log();
        base = beat_count;
        exp = '{32'h0001_0003, 32'hA1, 32'hA2,
                32'h0002_0003, 32'hB1, 32'hB2,
                32'h0003_0003, 32'hC1, 32'hC2};
        for (int m = 0; m < 3; m++) begin
            d = '0;
            d[31:0]  = exp[3*m+1];
            d[63:32] = exp[3*m+2];
            send_msg(16'(m + 1), LENW'(2), d, e0);
        end
        repeat (12) @(posedge CLK);
        #1;
        checks++;
        if (nrdy == 0) begin fails++; $display("[TB] FAIL b2b_ready_drop got=never_low want=low_while_full"); end
        checks++;
        if (bq.size() !== 9) begin fails++; $display("[TB] FAIL b2b_nbeats got=%0d want=9", bq.size()); end
        for (int i = 0; i < 9; i++) begin
            got = (i < bq.size()) ? bq[i] : 32'hxxxxxxxx;
            checks++;
            if (got !== exp[i]) begin fails++; $display("[TB] FAIL b2b_beat%0d got=%h want=%h", i, got, exp[i]); end
        end
        checks++;
        if (bq.size() == 9 && cq[8] - cq[0] !== 8) begin
            fails++; $display("[TB] FAIL b2b_gapless got_span=%0d want_span=8", cq[8] - cq[0]);
        end
        checks++;
        if (beat_count - base !== 32'd9) begin fails++; $display("[TB] FAIL b2b_count got=%0d want=9", beat_count - base); end
    endtask

    task automatic test_overlength();
        logic [DW-1:0] d;
        int e0;
        clear_log();
        checks++;
        if (len_err !== 1'b0) begin fails++; $display("[TB] FAIL ovl_pre_err got=%b want=0", len_err); end
        d = '0;
        d[31:0] = 32'h1234_5678;
        send_msg(16'd9, LENW'(17), d, e0);
        checks++;
        if (len_err !== 1'b1) begin fails++; $display("[TB] FAIL ovl_err_set got=%b want=1", len_err); end
        repeat (4) @(posedge CLK);
        #1;
        checks++;
        if (bq.size() !== 0) begin fails++; $display("[TB] FAIL ovl_nbeats got=%0d want=0", bq.size()); end
        d[31:0] = 32'hDEAD_BEEF;
        send_msg(16'h000A, LENW'(1), d, e0);
        repeat (5) @(posedge CLK);
        #1;
        checks++;
        if (bq.size() !== 2) begin fails++; $display("[TB] FAIL ovl_next_nbeats got=%0d want=2", bq.size()); end
        checks++;
        if (bq.size() > 0 && bq[0] !== 32'h000A_0002) begin fails++; $display("[TB] FAIL ovl_next_hdr got=%h want=000a0002", bq[0]); end
        checks++;
        if (bq.size() > 1 && bq[1] !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL ovl_next_word got=%h want=deadbeef", bq[1]); end
        checks++;
        if (len_err !== 1'b1) begin fails++; $display("[TB] FAIL ovl_sticky got=%b want=1", len_err); end
    endtask

    task automatic test_reset();
        @(posedge CLK); #3;
        RST = 1'b0;
        #1;
        checks++;
        if (en_beat !== 1'b0) begin fails++; $display("[TB] FAIL rst_en got=%b want=0", en_beat); end
        checks++;
        if (beat !== 32'd0) begin fails++; $display("[TB] FAIL rst_beat got=%h want=0", beat); end
        checks++;
        if (len_err !== 1'b0) begin fails++; $display("[TB] FAIL rst_len_err got=%b want=0", len_err); end
        checks++;
        if (beat_count !== 32'd0) begin fails++; $display("[TB] FAIL rst_count got=%0d want=0", beat_count); end
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (msg_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_ready got=%b want=1", msg_ready); end
        checks++;
        if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid_payload();
        logic [DW-1:0] d;
        int e0;
        clear_log();
        d = '0;
        d[31:0] = 32'h1; d[63:32] = 32'h2; d[95:64] = 32'h3; d[127:96] = 32'h4;
        send_msg(16'h000C, LENW'(4), d, e0);
        repeat (2) @(posedge CLK);
        #3;
        checks++;
        if (en_beat !== 1'b1 || beat !== 32'h1) begin
            fails++; $display("[TB] FAIL mid_word0 got_en=%b got_beat=%h want_en=1 want_beat=1", en_beat, beat);
        end
        RST = 1'b0;
        #1;
        checks++;
        if (en_beat !== 1'b0) begin fails++; $display("[TB] FAIL mid_async_en got=%b want=0", en_beat); end
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        clear_log();
        d = '0;
        d[31:0] = 32'h55;
        send_msg(16'h000D, LENW'(1), d, e0);
        repeat (8) @(posedge CLK);
        #1;
        checks++;
        if (bq.size() !== 2) begin fails++; $display("[TB] FAIL mid_new_nbeats got=%0d want=2", bq.size()); end
        checks++;
        if (bq.size() > 0 && bq[0] !== 32'h000D_0002) begin fails++; $display("[TB] FAIL mid_new_hdr got=%h want=000d0002", bq[0]); end
        checks++;
        if (bq.size() > 0 && cq[0] !== e0 + 1) begin fails++; $display("[TB] FAIL mid_new_edge got=%0d want=%0d", cq[0], e0 + 1); end
        checks++;
        if (bq.size() > 1 && bq[1] !== 32'h55) begin fails++; $display("[TB] FAIL mid_new_word got=%h want=55", bq[1]); end
        checks++;
        if (beat_count !== 32'd2) begin fails++; $display("[TB] FAIL mid_count got=%0d want=2", beat_count); end
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        test_single();
        test_zero_len();
        test_back_to_back();
        test_overlength();
        test_reset();
        test_reset_mid_payload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
